// File: rtl/sample_pkg.sv
// sample_pkg: shared constants and elaboration helpers for the sample stream blocks
package sample_pkg;
    localparam int BYTE_W = 8;
    function automatic int word_width(input int pack_bytes);
        return BYTE_W * pack_bytes;
    endfunction
    function automatic bit params_ok(input int pack_bytes, input int fifo_depth);
        return pack_bytes >= 2 && pack_bytes <= 8 && fifo_depth >= 2 && (fifo_depth & (fifo_depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/sample_word_fifo.sv
// sample_word_fifo: occupancy-counted word FIFO with sync clear
// Ports: clk_in/rst_low_in (async active-low), clear, push/wr_data, pop/rd_data (0 when empty), level/full/empty.
module sample_word_fifo
    import sample_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_low_in,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign empty   = level == '0;
    assign full    = level == LW'(DEPTH);
    assign do_pop  = pop && !empty;
    // a pop on the same edge frees the slot, so a full FIFO can still accept
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rptr];
    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
    always_ff @(posedge clk_in) begin
        if (do_push && !clear) mem[wptr] <= wr_data;
    end
endmodule

// File: rtl/sample_byte_packer.sv
// sample_byte_packer: packs accepted bytes little-endian into words and queues them
// Ports: clk_in/rst_low_in (async active-low), data_in/data_ready_in byte stream, clear_in sync clear,
//        word_out/word_valid_out/word_ready_in output handshake, level_out FIFO occupancy, overflow_out sticky drop flag.
module sample_byte_packer
    import sample_pkg::*;
#(
    parameter int PACK_BYTES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_low_in,
    input  logic [7:0]                          data_in,
    input  logic                                data_ready_in,
    input  logic                                clear_in,
    output logic [word_width(PACK_BYTES)-1:0]   word_out,
    output logic                                word_valid_out,
    input  logic                                word_ready_in,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     level_out,
    output logic                                overflow_out
);
    localparam int CW = $clog2(PACK_BYTES);
    localparam logic [CW-1:0] LAST = CW'(PACK_BYTES - 1);
    if (!params_ok(PACK_BYTES, FIFO_DEPTH)) begin : g_bad_params
        $error("sample_byte_packer: PACK_BYTES must be 2..8 and FIFO_DEPTH a power of two >= 2");
    end
    logic [CW-1:0] cnt;
    logic [BYTE_W*(PACK_BYTES-1)-1:0] lanes;
    logic fin, pop, full, empty;
    assign fin = data_ready_in && cnt == LAST;
    assign pop = word_valid_out && word_ready_in;
    assign word_valid_out = !empty;
    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            cnt          <= '0;
            lanes        <= '0;
            overflow_out <= 1'b0;
        end else if (clear_in) begin
            cnt          <= '0;
            lanes        <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (data_ready_in) begin
                cnt <= fin ? '0 : cnt + 1'b1;
                for (int i = 0; i < PACK_BYTES - 1; i++)
                    if (!fin && cnt == CW'(i)) lanes[i*BYTE_W +: BYTE_W] <= data_in;
            end
            if (fin && full && !pop) overflow_out <= 1'b1;
        end
    end
    // the final byte goes straight into the FIFO without passing through a lane
    sample_word_fifo #(.WIDTH(word_width(PACK_BYTES)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in     (clk_in),
        .rst_low_in (rst_low_in),
        .clear      (clear_in),
        .push       (fin),
        .wr_data    ({data_in, lanes}),
        .pop        (pop),
        .rd_data    (word_out),
        .level      (level_out),
        .full       (full),
        .empty      (empty)
    );
endmodule

// File: doc/sample_byte_packer.md
Name: sample_byte_packer

Overview:
- Sink side of the 8-bit data/ready byte stream produced by the sample data path.
- Collects accepted bytes into PACK_BYTES-wide words, little-endian.
- Buffers completed words in a small FIFO and presents them downstream on a valid/ready handshake.
- Reports FIFO occupancy and a sticky overflow flag for status registers.

Parameters:
PACK_BYTES, 4, bytes per output word; legal range 2..8.
FIFO_DEPTH, 4, completed-word FIFO entries; power of two, minimum 2.

Ports:
clk_in  input  1  single clock; all logic on posedge.
rst_low_in  input  1  asynchronous, active-low reset.
data_in  input  8  incoming byte.
data_ready_in  input  1  byte strobe; data_in is consumed on every posedge where this is 1; no backpressure upstream.
clear_in  input  1  synchronous clear of packer, FIFO and overflow.
word_out  output  8*PACK_BYTES  head-of-FIFO word; byte 0 in [7:0].
word_valid_out  output  1  FIFO not empty.
word_ready_in  input  1  downstream accept; pop when word_valid_out && word_ready_in.
level_out  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy 0..FIFO_DEPTH.
overflow_out  output  1  sticky: at least one completed word dropped.

Behaviour:
- Reset (rst_low_in=0, async assert, sync release): lane counter 0, assembly register 0, FIFO empty.
  - word_out=0, word_valid_out=0, level_out=0, overflow_out=0.
- Lane counter, range 0..PACK_BYTES-1 (this is the packer state; one state per lane):
  - On an accepted byte, the byte is written to lane[counter].
  - If counter < PACK_BYTES-1, counter increments.
  - If counter == PACK_BYTES-1 it is the final byte: counter wraps to 0 and the word completes.
- Completed word = stored lanes 0..PACK_BYTES-2 plus the current data_in in the top lane. No extra register stage.
- Push rule: the completed word is pushed the same edge it completes if the FIFO is not full OR a pop occurs on that edge.
- Latency: with the FIFO empty, word_valid_out rises on the cycle after the edge that accepted the final byte, and word_out holds the full word.
- Full FIFO, no pop, word completes:
  - The word is dropped and overflow_out is set on that edge.
  - Counter still wraps to 0.
  - FIFO contents are unchanged.
- Simultaneous push and pop: allowed at any level, including full. level_out is unchanged.
- Pop when empty: impossible, since valid=0.
- word_out is undefined-free: it shows the head entry when valid, and 0 when empty.
- word_out and word_valid_out must hold stable while valid=1 and ready=0.
- clear_in=1 takes priority over data, push and pop on that edge:
  - counter=0, lanes=0, FIFO emptied, overflow_out=0.
  - The byte presented on that edge is discarded.
- overflow_out is cleared only by clear_in or reset.
- Partial words are retained indefinitely across idle cycles; there is no timeout and no flush.
- Reset asserted mid-word or mid-handshake discards everything immediately (async).
- level_out is registered and reflects the post-edge occupancy.
- Width rules:
  - Counter width is $clog2(PACK_BYTES).
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; full/empty come from the occupancy count.

Decomposition:
- sample_pkg:
  - BYTE_W=8 constant.
  - Function for word width (BYTE_W*PACK_BYTES).
  - Elaboration-time parameter checks (PACK_BYTES range, FIFO_DEPTH power of two).
- Sub-module sample_word_fifo (parameters WIDTH, DEPTH):
  - push/pop/data/level/full/empty.
  - Synchronous clear, async active-low reset.
  - Reused by later stream blocks.
- The packer logic (counter, lanes, overflow) stays in sample_byte_packer.

Test Plan:
1. Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles with word_ready_in=1 -> one cycle after 0x44: word_valid_out=1, word_out=0x44332211, level_out=1; popped next edge, level_out=0.
2. Idle gaps: bytes 0xAA, 3 idle cycles, 0xBB, 0xCC, 5 idle, 0xDD -> word_out=0xDDCCBBAA; no valid before the final byte.
3. word_ready_in=0, 20 consecutive bytes 0x01..0x14:
   - FIFO fills with 0x04030201..0x100F0E0D, level_out=4.
   - The fifth word 0x14131211 is dropped and overflow_out=1.
   - Raising ready drains exactly the 4 stored words in order.
4. FIFO full and word_ready_in=1 on the same edge as a final byte -> no drop, level_out stays 4, overflow_out stays 0, new word appears at the tail.
5. Two bytes 0x55,0x66 accepted, then clear_in=1 with data_ready_in=1 and data 0x77 -> counter 0, overflow 0, FIFO empty; next 0x01,0x02,0x03,0x04 yields 0x04030201.
6. rst_low_in pulsed low mid-word and while word_valid_out=1 with ready=0 -> all outputs 0 asynchronously; the next full 4-byte group packs correctly from lane 0.
